// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed registers behind independent
// write and read FSMs. Register contents and post-write pulses go to user logic.

// One register of the bank; byte lanes with strobe low keep their value.
module axi_lite_reg_cell #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    pulse
);
  // byte-merge on write; pulse marks the cycle after any valid write
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= we;
      if (we)
        for (int b = 0; b < DATA_WIDTH/8; b++)
          if (wstrb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end
endmodule

module axi_lite_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int NUM_REGS   = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]          s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [RESP_WIDTH-1:0]          s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [RESP_WIDTH-1:0]          s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int STRB_W   = DATA_WIDTH/8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Offset from base wraps modulo the address width, so addresses below the
  // base land on huge offsets and fail the range check.
  function automatic logic [ADDR_WIDTH-1:0] addr_off(input logic [ADDR_WIDTH-1:0] a);
    return a - ADDR_WIDTH'(BASE_ADDR);
  endfunction

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = addr_off(a);
    return ((off & ADDR_WIDTH'(STRB_W-1)) == '0) &&
           ((off >> ADDR_LSB) < ADDR_WIDTH'(NUM_REGS));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return addr_off(a) >> ADDR_LSB;
  endfunction

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_q;

  // ---------------- write path ----------------
  w_state_t              w_state, w_state_nx;
  logic                  aw_cap, w_cap, commit;
  logic [ADDR_WIDTH-1:0] aw_addr_q, wr_addr, wr_idx;
  logic [DATA_WIDTH-1:0] wdata_q, wr_data;
  logic [STRB_W-1:0]     wstrb_q, wr_strb;
  logic                  aw_hs, w_hs, wr_ok;
  logic                  unused_strb_msb;

  assign unused_strb_msb = s_axi_wstrb[STRB_W];
  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign wr_addr = aw_cap ? aw_addr_q : s_axi_awaddr;
  assign wr_data = w_cap ? wdata_q : s_axi_wdata;
  assign wr_strb = w_cap ? wstrb_q : s_axi_wstrb[STRB_W-1:0];
  assign wr_ok   = addr_ok(wr_addr);
  assign wr_idx  = addr_idx(wr_addr);

  // write FSM state register
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) w_state <= W_IDLE;
    else              w_state <= w_state_nx;
  end

  // write FSM next state, readies, and commit when address and data are both in hand
  always_comb begin
    w_state_nx    = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    commit        = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = !aw_cap;
        s_axi_wready  = !w_cap;
        if ((aw_cap || s_axi_awvalid) && (w_cap || s_axi_wvalid)) begin
          commit     = 1'b1;
          w_state_nx = W_RESP;
        end
      end
      W_RESP: if (s_axi_bready) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  // capture AW/W halves, raise B on commit, drop it on the B handshake
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      aw_cap       <= 1'b0;
      w_cap        <= 1'b0;
      aw_addr_q    <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else if (commit) begin
      aw_cap       <= 1'b0;
      w_cap        <= 1'b0;
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_cap    <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_cap   <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb[STRB_W-1:0];
      end
      if (w_state == W_RESP && s_axi_bready) s_axi_bvalid <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      axi_lite_reg_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
        .clk   (s_axi_aclk),
        .rst   (s_axi_areset),
        .we    (commit && wr_ok && (wr_idx == ADDR_WIDTH'(gi))),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .q     (reg_q[gi]),
        .pulse (wr_pulse[gi])
      );
    end
  endgenerate

  assign reg_out = reg_q;

  // ---------------- read path ----------------
  r_state_t              r_state, r_state_nx;
  logic                  ar_hs, rd_ok;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] rd_val;

  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign rd_ok  = addr_ok(s_axi_araddr);
  assign rd_idx = addr_idx(s_axi_araddr);

  // read mux over the registers as held before this edge
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_idx == ADDR_WIDTH'(i)) rd_val = reg_q[i];
  end

  // read FSM state register
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) r_state <= R_IDLE;
    else              r_state <= r_state_nx;
  end

  // read FSM next state; one read outstanding at most
  always_comb begin
    r_state_nx    = r_state;
    s_axi_arready = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) r_state_nx = R_DATA;
      end
      R_DATA: if (s_axi_rready) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  // load R beat on AR handshake, hold it until the R handshake
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_ok ? rd_val : '0;
      s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_state == R_DATA && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Randomized self-checking bench for axi_lite_reg_slave against a
// register-array reference model.
module tb_axi_lite_reg_slave;
  localparam int DW = 32, AW = 8, RW = 3, NR = 4, BASE = 0, SB = DW/8;

  logic              clk = 1'b0, rst = 1'b1;
  logic [AW-1:0]     s_axi_awaddr = '0, s_axi_araddr = '0;
  logic              s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_arvalid = 0;
  logic              s_axi_bready = 1, s_axi_rready = 1;
  logic [DW-1:0]     s_axi_wdata = '0;
  logic [SB:0]       s_axi_wstrb = '0;
  logic              s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [RW-1:0]     s_axi_bresp, s_axi_rresp;
  logic [DW-1:0]     s_axi_rdata;
  logic [NR*DW-1:0]  reg_out;
  logic [NR-1:0]     wr_pulse;

  int n_cmp = 0, n_err = 0;
  int pcnt[NR];
  logic [DW-1:0] mdl[NR];

  always #5 clk = ~clk;

  axi_lite_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW),
                       .NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse));

  // count cycles each register's write pulse is high
  always @(negedge clk)
    if (!rst) for (int i = 0; i < NR; i++) if (wr_pulse[i]) pcnt[i]++;

  // ---- reference model ----
  function automatic bit m_valid(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - AW'(BASE);
    return (int'(off) % SB == 0) && (int'(off) / SB < NR);
  endfunction

  function automatic int m_idx(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - AW'(BASE);
    return int'(off) / SB;
  endfunction

  task automatic m_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SB:0] s);
    if (m_valid(a))
      for (int b = 0; b < SB; b++) if (s[b]) mdl[m_idx(a)][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // ---- bus drivers (start and end at posedge+1) ----
  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SB:0] s,
                           input int da, input int dw, output logic [RW-1:0] resp,
                           output int lat, output bit ok);
    bit ad, wd, af, wf;
    int c;
    ad = 0; wd = 0; c = 0; ok = 1;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    while (!(ad && wd) && ok) begin
      s_axi_awvalid = !ad && (c >= da);
      s_axi_wvalid  = !wd && (c >= dw);
      @(negedge clk);
      af = s_axi_awvalid && s_axi_awready;
      wf = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      if (af) ad = 1;
      if (wf) wd = 1;
      c++;
      if (c > 50) ok = 0;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    lat = c;
    @(negedge clk);
    if (!s_axi_bvalid) ok = 0;
    resp = s_axi_bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                          output logic [RW-1:0] r, output bit ok);
    bit f;
    int c;
    c = 0; ok = 1; f = 0;
    s_axi_araddr = a; s_axi_arvalid = 1; s_axi_rready = 1;
    while (!f && ok) begin
      @(negedge clk);
      f = s_axi_arready;
      @(posedge clk); #1;
      c++;
      if (c > 50) ok = 0;
    end
    s_axi_arvalid = 0;
    @(negedge clk);
    if (!s_axi_rvalid) ok = 0;
    d = s_axi_rdata; r = s_axi_rresp;
    @(posedge clk); #1;
  endtask

  // ---- tests ----
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      n_err++; $display("FAIL reset_ready got=%b want=111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    n_cmp++;
    if ({s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata, wr_pulse} !== '0) begin
      n_err++; $display("FAIL reset_outputs bv=%b rv=%b br=%0d rr=%0d rd=%h p=%b want all 0",
        s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata, wr_pulse);
    end
    n_cmp++;
    if (reg_out !== '0) begin n_err++; $display("FAIL reset_regs got=%h want=0", reg_out); end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_basic;
    logic [RW-1:0] r; logic [DW-1:0] d; int lat; bit ok; int p0[NR];
    p0 = pcnt;
    axi_write(8'h04, 32'hDEADBEEF, 5'h0F, 0, 0, r, lat, ok);
    m_write(8'h04, 32'hDEADBEEF, 5'h0F);
    n_cmp++;
    if (!ok || lat != 1) begin n_err++; $display("FAIL basic_wr_latency ok=%0d lat=%0d want lat=1", ok, lat); end
    n_cmp++;
    if (r !== 3'd0) begin n_err++; $display("FAIL basic_bresp got=%0d want=0", r); end
    n_cmp++;
    if (reg_out[1*DW +: DW] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL basic_reg1 got=%h want=deadbeef", reg_out[1*DW +: DW]);
    end
    axi_read(8'h04, d, r, ok);
    n_cmp++;
    if (!ok || d !== mdl[1] || r !== 3'd0) begin
      n_err++; $display("FAIL basic_read ok=%0d got=%h/%0d want=%h/0", ok, d, r, mdl[1]);
    end
    for (int i = 0; i < NR; i++) begin
      n_cmp++;
      if (pcnt[i] - p0[i] != (i == 1 ? 1 : 0)) begin
        n_err++; $display("FAIL basic_pulse[%0d] got=%0d want=%0d", i, pcnt[i] - p0[i], i == 1);
      end
    end
  endtask

  task automatic test_w_first;
    logic [RW-1:0] r; int lat; bit ok;
    s_axi_wdata = 32'h11223344; s_axi_wstrb = 5'h0F; s_axi_wvalid = 1;
    @(negedge clk);
    n_cmp++;
    if (s_axi_wready !== 1'b1) begin n_err++; $display("FAIL wfirst_wready0 got=%b want=1", s_axi_wready); end
    @(posedge clk); #1;
    s_axi_wvalid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
        n_err++; $display("FAIL wfirst_wait%0d wready=%b bvalid=%b awready=%b want 0/0/1",
          k, s_axi_wready, s_axi_bvalid, s_axi_awready);
      end
      @(posedge clk); #1;
    end
    s_axi_awaddr = 8'h08; s_axi_awvalid = 1;
    @(posedge clk); #1;
    s_axi_awvalid = 0;
    m_write(8'h08, 32'h11223344, 5'h0F);
    @(negedge clk);
    n_cmp++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 3'd0 || reg_out[2*DW +: DW] !== mdl[2]) begin
      n_err++; $display("FAIL wfirst_commit bvalid=%b bresp=%0d reg2=%h want 1/0/%h",
        s_axi_bvalid, s_axi_bresp, reg_out[2*DW +: DW], mdl[2]);
    end
    @(posedge clk); #1;
    axi_write(8'h08, 32'hAABBCCDD, 5'h05, 0, 0, r, lat, ok);
    m_write(8'h08, 32'hAABBCCDD, 5'h05);
    n_cmp++;
    if (!ok || reg_out[2*DW +: DW] !== 32'h11BB33DD || mdl[2] !== 32'h11BB33DD) begin
      n_err++; $display("FAIL wfirst_strobe ok=%0d reg2=%h want=11bb33dd", ok, reg_out[2*DW +: DW]);
    end
  endtask

  task automatic test_errors;
    logic [RW-1:0] r; logic [DW-1:0] d; int lat; bit ok; int p0[NR];
    p0 = pcnt;
    axi_write(8'h10, 32'hCAFEF00D, 5'h0F, 1, 0, r, lat, ok);
    @(posedge clk); #1;
    n_cmp++;
    if (!ok || r !== 3'd2) begin n_err++; $display("FAIL err_bresp ok=%0d got=%0d want=2", ok, r); end
    for (int i = 0; i < NR; i++) begin
      n_cmp++;
      if (reg_out[i*DW +: DW] !== mdl[i] || pcnt[i] != p0[i]) begin
        n_err++; $display("FAIL err_nochange[%0d] reg=%h want=%h pulses=%0d want=0",
          i, reg_out[i*DW +: DW], mdl[i], pcnt[i] - p0[i]);
      end
    end
    axi_read(8'h02, d, r, ok);
    n_cmp++;
    if (!ok || d !== '0 || r !== 3'd2) begin
      n_err++; $display("FAIL err_misaligned_read ok=%0d got=%h/%0d want=0/2", ok, d, r);
    end
    axi_read(8'h10, d, r, ok);
    n_cmp++;
    if (!ok || d !== '0 || r !== 3'd2) begin
      n_err++; $display("FAIL err_range_read ok=%0d got=%h/%0d want=0/2", ok, d, r);
    end
  endtask

  task automatic test_b_stall;
    logic [RW-1:0] r; logic [DW-1:0] d0, d1; int lat; bit ok;
    d0 = $urandom; d1 = $urandom;
    s_axi_bready = 0;
    axi_write(8'h00, d0, 5'h0F, 0, 0, r, lat, ok);
    m_write(8'h00, d0, 5'h0F);
    s_axi_awaddr = 8'h04; s_axi_awvalid = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 3'd0 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin
        n_err++; $display("FAIL bstall_hold%0d bvalid=%b bresp=%0d awready=%b wready=%b want 1/0/0/0",
          k, s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready);
      end
      @(posedge clk); #1;
    end
    s_axi_bready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
      n_err++; $display("FAIL bstall_release bvalid=%b awready=%b want 0/1", s_axi_bvalid, s_axi_awready);
    end
    @(posedge clk); #1;
    s_axi_awvalid = 0;
    @(negedge clk);
    n_cmp++;
    if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b1) begin
      n_err++; $display("FAIL bstall_awcap awready=%b wready=%b want 0/1", s_axi_awready, s_axi_wready);
    end
    s_axi_wdata = d1; s_axi_wstrb = 5'h0F; s_axi_wvalid = 1;
    @(posedge clk); #1;
    s_axi_wvalid = 0;
    m_write(8'h04, d1, 5'h0F);
    @(negedge clk);
    n_cmp++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 3'd0 || reg_out[DW-1:0] !== mdl[0] || reg_out[DW +: DW] !== mdl[1]) begin
      n_err++; $display("FAIL bstall_second bvalid=%b bresp=%0d r0=%h r1=%h want 1/0/%h/%h",
        s_axi_bvalid, s_axi_bresp, reg_out[DW-1:0], reg_out[DW +: DW], mdl[0], mdl[1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_r_stall;
    logic [RW-1:0] r; logic [DW-1:0] d, old, nv; int lat; bit ok;
    old = mdl[3]; nv = $urandom;
    s_axi_araddr = 8'h0C; s_axi_arvalid = 1; s_axi_rready = 0;
    @(posedge clk); #1;
    s_axi_arvalid = 0;
    axi_write(8'h0C, nv, 5'h0F, 0, 0, r, lat, ok);
    m_write(8'h0C, nv, 5'h0F);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== old || s_axi_rresp !== 3'd0 || s_axi_arready !== 1'b0) begin
        n_err++; $display("FAIL rstall_hold%0d rvalid=%b rdata=%h rresp=%0d arready=%b want 1/%h/0/0",
          k, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_arready, old);
      end
      @(posedge clk); #1;
    end
    s_axi_rready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      n_err++; $display("FAIL rstall_release rvalid=%b arready=%b want 0/1", s_axi_rvalid, s_axi_arready);
    end
    axi_read(8'h0C, d, r, ok);
    n_cmp++;
    if (!ok || d !== mdl[3] || r !== 3'd0) begin
      n_err++; $display("FAIL rstall_newval ok=%0d got=%h/%0d want=%h/0", ok, d, r, mdl[3]);
    end
  endtask

  task automatic test_same_edge;
    int ix; logic [AW-1:0] a; logic [DW-1:0] old, nv;
    ix = $urandom_range(0, NR-1); a = AW'(ix*SB); old = mdl[ix]; nv = $urandom;
    s_axi_awaddr = a; s_axi_araddr = a; s_axi_wdata = nv; s_axi_wstrb = 5'h0F;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
    @(posedge clk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    m_write(a, nv, 5'h0F);
    @(negedge clk);
    n_cmp++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== old || s_axi_bvalid !== 1'b1 || reg_out[ix*DW +: DW] !== mdl[ix]) begin
      n_err++; $display("FAIL same_edge rv=%b rd=%h bv=%b reg=%h want 1/%h/1/%h",
        s_axi_rvalid, s_axi_rdata, s_axi_bvalid, reg_out[ix*DW +: DW], old, mdl[ix]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [RW-1:0] r; logic [DW-1:0] d; logic [AW-1:0] a; logic [SB:0] s;
    int lat; bit ok; int p0[NR];
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, 1) ? AW'(SB * $urandom_range(0, NR+1)) : AW'($urandom_range(0, 31));
      if ($urandom_range(0, 1)) begin
        d = $urandom; s = SB'($urandom_range(0, 2**(SB+1)-1));
        p0 = pcnt;
        axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), r, lat, ok);
        m_write(a, d, s);
        @(posedge clk); #1;
        n_cmp++;
        if (!ok || r !== (m_valid(a) ? 3'd0 : 3'd2)) begin
          n_err++; $display("FAIL rnd_bresp a=%h ok=%0d got=%0d valid=%0d", a, ok, r, m_valid(a));
        end
        for (int i = 0; i < NR; i++) begin
          n_cmp++;
          if (reg_out[i*DW +: DW] !== mdl[i] || pcnt[i] - p0[i] != ((m_valid(a) && m_idx(a) == i) ? 1 : 0)) begin
            n_err++; $display("FAIL rnd_wr[%0d] a=%h reg=%h want=%h pulses=%0d", i, a,
              reg_out[i*DW +: DW], mdl[i], pcnt[i] - p0[i]);
          end
        end
      end else begin
        axi_read(a, d, r, ok);
        n_cmp++;
        if (!ok || d !== (m_valid(a) ? mdl[m_idx(a) % NR] : '0) || r !== (m_valid(a) ? 3'd0 : 3'd2)) begin
          n_err++; $display("FAIL rnd_rd a=%h ok=%0d got=%h/%0d valid=%0d", a, ok, d, r, m_valid(a));
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [RW-1:0] r; int lat; bit ok;
    s_axi_bready = 0;
    axi_write(8'h04, 32'h5A5A5A5A, 5'h0F, 0, 0, r, lat, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rstmid_bvalid got=0 want=1"); end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    @(negedge clk);
    n_cmp++;
    if (s_axi_bvalid !== 1'b0 || {s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111 || reg_out !== '0) begin
      n_err++; $display("FAIL rstmid_state bvalid=%b rdy=%b regs=%h want 0/111/0",
        s_axi_bvalid, {s_axi_awready, s_axi_wready, s_axi_arready}, reg_out);
    end
    s_axi_bready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (s_axi_bvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_noresp bvalid=%b want=0", s_axi_bvalid); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_w_first;
    test_errors;
    test_b_stall;
    test_r_stall;
    test_same_edge;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    for (int i = 0; i < NR; i++) begin mdl[i] = '0; pcnt[i] = 0; end
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
